hls_activity_monitor: RTL and testbench

- Synthesizable run-time monitor that samples the block-level handshake (ap_start/ap_ready/ap_done/ap_continue) of one HLS module and the FSM/pipeline status of one pipelined loop.
- Produces transaction, iteration and cycle counters for on-chip profiling.
- Sits beside the monitored instance; all inputs are read-only taps, so it never affects the design.

---
 rtl/hls_activity_monitor.sv | 155 +++++++++++++++
 tb/tb_hls_activity_monitor.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hls_activity_monitor.sv
// Passive profiling monitor for one HLS module handshake and one pipelined loop.
// Counts transactions, invocations, iterations, stalls and busy cycles.
module hls_activity_monitor #(
    parameter int ST_W  = 1,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic [ST_W-1:0]  cur_state,
    input  logic [ST_W-1:0]  iter_start_state,
    input  logic [ST_W-1:0]  iter_end_state,
    input  logic [ST_W-1:0]  quit_state,
    input  logic             iter_start_block,
    input  logic             iter_end_block,
    input  logic             quit_block,
    input  logic             iter_start_enable,
    input  logic             iter_end_enable,
    input  logic             quit_enable,
    input  logic             loop_start,
    input  logic             loop_ready,
    input  logic             loop_done,
    input  logic             loop_continue,
    input  logic             quit_at_end,
    input  logic             finish,
    output logic [1:0]       mod_state,
    output logic [CNT_W-1:0] mod_txn_cnt,
    output logic [CNT_W-1:0] mod_ready_cnt,
    output logic [CNT_W-1:0] mod_busy_cyc,
    output logic             loop_active,
    output logic [CNT_W-1:0] loop_inv_cnt,
    output logic [CNT_W-1:0] iter_start_cnt,
    output logic [CNT_W-1:0] iter_end_cnt,
    output logic [CNT_W-1:0] iter_inflight,
    output logic [CNT_W-1:0] loop_stall_cyc,
    output logic [CNT_W-1:0] loop_quit_cnt,
    output logic             frozen
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        WAIT_CONT = 2'd2
    } mod_state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v,
        input logic             en
    );
        return (en && v != '1) ? v + ONE : v;
    endfunction

    mod_state_t state_q, state_d;
    logic       txn_ev;
    logic       run;
    logic       win;
    logic       start_ev, end_ev, quit_ev, stall_ev;
    logic       inv_ev;
    logic       loop_active_d;

    // Nothing moves on or after the first sampled finish.
    assign run = !frozen && !finish;

    assign start_ev = (cur_state == iter_start_state) && iter_start_enable
                      && !iter_start_block;
    assign end_ev   = (cur_state == iter_end_state) && iter_end_enable
                      && !iter_end_block;
    assign quit_ev  = (cur_state == quit_state) && quit_enable && !quit_block
                      && (quit_at_end ? end_ev : 1'b1);
    assign stall_ev = (cur_state == iter_start_state) && iter_start_block;

    assign inv_ev = loop_start && !loop_active;
    assign win    = loop_active || loop_start;

    always_comb begin
        loop_active_d = loop_active;
        if (win && loop_done && loop_continue)
            loop_active_d = 1'b0;
        else if (inv_ev)
            loop_active_d = 1'b1;
    end

    // IDLE falls through to the RUN rules so start+done is one transaction.
    always_comb begin
        state_d = state_q;
        txn_ev  = 1'b0;
        unique case (state_q)
            IDLE, RUN: begin
                if (state_q == RUN || ap_start) begin
                    state_d = RUN;
                    if (ap_done && ap_continue) begin
                        state_d = IDLE;
                        txn_ev  = 1'b1;
                    end else if (ap_done) begin
                        state_d = WAIT_CONT;
                    end
                end
            end
            WAIT_CONT: begin
                if (ap_continue) begin
                    state_d = IDLE;
                    txn_ev  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mod_state = state_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            frozen         <= 1'b0;
            mod_txn_cnt    <= '0;
            mod_ready_cnt  <= '0;
            mod_busy_cyc   <= '0;
            loop_active    <= 1'b0;
            loop_inv_cnt   <= '0;
            iter_start_cnt <= '0;
            iter_end_cnt   <= '0;
            iter_inflight  <= '0;
            loop_stall_cyc <= '0;
            loop_quit_cnt  <= '0;
        end else begin
            if (finish)
                frozen <= 1'b1;
            if (run) begin
                state_q        <= state_d;
                mod_txn_cnt    <= sat_inc(mod_txn_cnt, txn_ev);
                mod_ready_cnt  <= sat_inc(mod_ready_cnt, ap_ready);
                mod_busy_cyc   <= sat_inc(mod_busy_cyc, state_q != IDLE);
                loop_active    <= loop_active_d;
                loop_inv_cnt   <= sat_inc(loop_inv_cnt, inv_ev);
                iter_start_cnt <= sat_inc(iter_start_cnt, win && start_ev);
                iter_end_cnt   <= sat_inc(iter_end_cnt, win && end_ev);
                loop_stall_cyc <= sat_inc(loop_stall_cyc, win && stall_ev);
                loop_quit_cnt  <= sat_inc(loop_quit_cnt, win && quit_ev);
                if (win && start_ev && !end_ev)
                    iter_inflight <= sat_inc(iter_inflight, 1'b1);
                else if (win && end_ev && !start_ev && iter_inflight != '0)
                    iter_inflight <= iter_inflight - ONE;
            end
        end
    end

    logic unused;
    assign unused = loop_ready;

endmodule

// File: tb/tb_hls_activity_monitor.sv
// Directed bench for hls_activity_monitor: handshake, back-pressure, loop,
// freeze, asynchronous reset and 4-bit saturation.
module tb_hls_activity_monitor;

    logic       clock = 1'b0;
    logic       reset;
    logic       ap_start, ap_ready, ap_done, ap_continue;
    logic [0:0] cur_state, iter_start_state, iter_end_state, quit_state;
    logic       iter_start_block, iter_end_block, quit_block;
    logic       iter_start_enable, iter_end_enable, quit_enable;
    logic       loop_start, loop_ready, loop_done, loop_continue;
    logic       quit_at_end, finish;

    logic [1:0]  mod_state, s_mod_state;
    logic [31:0] mod_txn_cnt, mod_ready_cnt, mod_busy_cyc;
    logic [31:0] loop_inv_cnt, iter_start_cnt, iter_end_cnt;
    logic [31:0] iter_inflight, loop_stall_cyc, loop_quit_cnt;
    logic        loop_active, frozen, s_loop_active, s_frozen;
    logic [3:0]  s_txn, s_ready, s_busy, s_inv, s_istart, s_iend;
    logic [3:0]  s_infl, s_stall, s_quit;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    hls_activity_monitor dut (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue),
        .cur_state(cur_state), .iter_start_state(iter_start_state),
        .iter_end_state(iter_end_state), .quit_state(quit_state),
        .iter_start_block(iter_start_block),
        .iter_end_block(iter_end_block), .quit_block(quit_block),
        .iter_start_enable(iter_start_enable),
        .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
        .loop_start(loop_start), .loop_ready(loop_ready),
        .loop_done(loop_done), .loop_continue(loop_continue),
        .quit_at_end(quit_at_end), .finish(finish),
        .mod_state(mod_state), .mod_txn_cnt(mod_txn_cnt),
        .mod_ready_cnt(mod_ready_cnt), .mod_busy_cyc(mod_busy_cyc),
        .loop_active(loop_active), .loop_inv_cnt(loop_inv_cnt),
        .iter_start_cnt(iter_start_cnt), .iter_end_cnt(iter_end_cnt),
        .iter_inflight(iter_inflight), .loop_stall_cyc(loop_stall_cyc),
        .loop_quit_cnt(loop_quit_cnt), .frozen(frozen)
    );

    hls_activity_monitor #(.ST_W(1), .CNT_W(4)) dut_sat (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue),
        .cur_state(cur_state), .iter_start_state(iter_start_state),
        .iter_end_state(iter_end_state), .quit_state(quit_state),
        .iter_start_block(iter_start_block),
        .iter_end_block(iter_end_block), .quit_block(quit_block),
        .iter_start_enable(iter_start_enable),
        .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
        .loop_start(loop_start), .loop_ready(loop_ready),
        .loop_done(loop_done), .loop_continue(loop_continue),
        .quit_at_end(quit_at_end), .finish(finish),
        .mod_state(s_mod_state), .mod_txn_cnt(s_txn),
        .mod_ready_cnt(s_ready), .mod_busy_cyc(s_busy),
        .loop_active(s_loop_active), .loop_inv_cnt(s_inv),
        .iter_start_cnt(s_istart), .iter_end_cnt(s_iend),
        .iter_inflight(s_infl), .loop_stall_cyc(s_stall),
        .loop_quit_cnt(s_quit), .frozen(s_frozen)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_state"}, mod_state, 0);
        chk({tag, "_txn"}, mod_txn_cnt, 0);
        chk({tag, "_ready"}, mod_ready_cnt, 0);
        chk({tag, "_busy"}, mod_busy_cyc, 0);
        chk({tag, "_active"}, loop_active, 0);
        chk({tag, "_inv"}, loop_inv_cnt, 0);
        chk({tag, "_istart"}, iter_start_cnt, 0);
        chk({tag, "_iend"}, iter_end_cnt, 0);
        chk({tag, "_infl"}, iter_inflight, 0);
        chk({tag, "_stall"}, loop_stall_cyc, 0);
        chk({tag, "_quit"}, loop_quit_cnt, 0);
        chk({tag, "_frozen"}, frozen, 0);
        chk({tag, "_sat_ready"}, s_ready, 0);
    endtask

    initial begin
        reset = 1'b0;
        {ap_start, ap_ready, ap_done} = '0;
        ap_continue = 1'b1;
        cur_state = '0;
        iter_start_state = '0;
        iter_end_state = '0;
        quit_state = '0;
        {iter_start_block, iter_end_block, quit_block} = '0;
        {iter_start_enable, iter_end_enable, quit_enable} = '0;
        {loop_start, loop_ready, loop_done} = '0;
        loop_continue = 1'b1;
        quit_at_end = 1'b0;
        finish = 1'b0;
        repeat (2) step();
        check_all_zero("rst");
        reset = 1'b1;

        // Module handshake: start at C0, done at C5.
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        chk("hs_run", mod_state, 1);
        repeat (4) step();
        ap_done = 1'b1;
        ap_ready = 1'b1;
        step();
        ap_done = 1'b0;
        ap_ready = 1'b0;
        chk("hs_idle", mod_state, 0);
        chk("hs_txn", mod_txn_cnt, 1);
        chk("hs_busy", mod_busy_cyc, 5);
        chk("hs_ready", mod_ready_cnt, 1);

        // Continue back-pressure.
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        ap_done = 1'b1;
        ap_continue = 1'b0;
        step();
        ap_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_wait", mod_state, 2);
            chk("bp_txn_hold", mod_txn_cnt, 1);
            if (i < 2) step();
        end
        ap_continue = 1'b1;
        step();
        chk("bp_idle", mod_state, 0);
        chk("bp_txn", mod_txn_cnt, 2);
        chk("bp_busy", mod_busy_cyc, 9);

        // Pipelined loop: C0..C9.
        for (int c = 0; c < 10; c++) begin
            loop_start = (c == 0);
            iter_start_enable = (c <= 8);
            iter_start_block = (c == 2);
            iter_end_enable = (c >= 2);
            loop_done = (c == 9);
            quit_enable = (c == 9);
            quit_at_end = 1'b1;
            step();
            if (c == 2) begin
                chk("lp_mid_istart", iter_start_cnt, 2);
                chk("lp_mid_iend", iter_end_cnt, 1);
                chk("lp_mid_infl", iter_inflight, 1);
                chk("lp_mid_stall", loop_stall_cyc, 1);
                chk("lp_mid_active", loop_active, 1);
            end
        end
        {loop_start, iter_start_enable, iter_start_block} = '0;
        {iter_end_enable, loop_done, quit_enable, quit_at_end} = '0;
        chk("lp_inv", loop_inv_cnt, 1);
        chk("lp_istart", iter_start_cnt, 8);
        chk("lp_iend", iter_end_cnt, 8);
        chk("lp_stall", loop_stall_cyc, 1);
        chk("lp_infl", iter_inflight, 0);
        chk("lp_active", loop_active, 0);
        chk("lp_quit", loop_quit_cnt, 1);

        // Start+done same cycle, end event with nothing in flight.
        loop_start = 1'b1;
        loop_done = 1'b1;
        iter_end_enable = 1'b1;
        step();
        {loop_start, loop_done, iter_end_enable} = '0;
        chk("sd_inv", loop_inv_cnt, 2);
        chk("sd_active", loop_active, 0);
        chk("sd_iend", iter_end_cnt, 9);
        chk("sd_infl", iter_inflight, 0);

        // Freeze during an active loop.
        loop_start = 1'b1;
        iter_start_enable = 1'b1;
        step();
        loop_start = 1'b0;
        chk("fz_pre_istart", iter_start_cnt, 9);
        chk("fz_pre_infl", iter_inflight, 1);
        finish = 1'b1;
        ap_ready = 1'b1;
        ap_start = 1'b1;
        step();
        finish = 1'b0;
        step();
        step();
        ap_ready = 1'b0;
        ap_start = 1'b0;
        iter_start_enable = 1'b0;
        chk("fz_frozen", frozen, 1);
        chk("fz_istart", iter_start_cnt, 9);
        chk("fz_inv", loop_inv_cnt, 3);
        chk("fz_ready", mod_ready_cnt, 1);
        chk("fz_state", mod_state, 0);
        chk("fz_busy", mod_busy_cyc, 9);
        chk("fz_active", loop_active, 1);

        // Asynchronous reset away from any clock edge.
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("arst");
        step();
        reset = 1'b1;

        // Saturation on the 4-bit instance; counting resumes after reset.
        ap_ready = 1'b1;
        repeat (20) step();
        ap_ready = 1'b0;
        chk("sat_ready4", s_ready, 15);
        chk("sat_ready32", mod_ready_cnt, 20);
        chk("sat_frozen", s_frozen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
